// File: rtl/gen_scl.sv
// gen_scl: programmable SCL clock generator for the I2C master.
// Divides the system clock into a 50% duty-cycle SCL. Each phase lasts
// div_q+1 clocks. The divider is latched from i_TWIBR on start and at
// every half-period boundary, so a TWIBR change never produces a short phase.
module gen_scl #(
    parameter int SIZE_REG = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_SCL_start,
    input  logic                i_SCL_en,
    input  logic [SIZE_REG-1:0] i_TWIBR,
    output logic                o_SCL
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [SIZE_REG-1:0] cnt;
    logic [SIZE_REG-1:0] div_q;

    // Single FSM: idle/run control, half-period counter and registered SCL.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            div_q <= '0;
            o_SCL <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    o_SCL <= 1'b1;
                    cnt   <= '0;
                    if (i_SCL_en && i_SCL_start) begin
                        state <= RUN;
                        div_q <= i_TWIBR;
                    end
                end
                RUN: begin
                    // Disable has priority over a coinciding phase boundary.
                    if (!i_SCL_en) begin
                        state <= IDLE;
                        o_SCL <= 1'b1;
                        cnt   <= '0;
                    end else if (cnt == div_q) begin
                        o_SCL <= ~o_SCL;
                        cnt   <= '0;
                        div_q <= i_TWIBR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    o_SCL <= 1'b1;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gen_scl.sv
// Directed testbench for gen_scl.
module tb_gen_scl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_SCL_start;
    logic        i_SCL_en;
    logic [15:0] i_TWIBR;
    logic        o_SCL;

    int checks;
    int errors;

    gen_scl #(.SIZE_REG(16)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_SCL_start(i_SCL_start),
        .i_SCL_en   (i_SCL_en),
        .i_TWIBR    (i_TWIBR),
        .o_SCL      (o_SCL)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Return the generator to idle with enable low.
    task automatic go_idle();
        i_SCL_en    = 1'b0;
        i_SCL_start = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic exp;
        exp = 1'b1;
        i_rst_n     = 1'b0;
        i_SCL_en    = 1'b1;
        i_SCL_start = 1'b1;
        i_TWIBR     = 16'd4;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (o_SCL !== exp) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: o_SCL=%b expected %b", k, o_SCL, exp);
            end
        end
        i_SCL_start = 1'b0;
        i_rst_n     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (o_SCL !== exp) begin
                errors++;
                $display("FAIL reset_release cycle %0d: o_SCL=%b expected %b", k, o_SCL, exp);
            end
        end
    endtask

    // TWIBR=4: phases of 5 cycles; start held 2 cycles, then a stray start in RUN.
    task automatic test_basic();
        logic exp;
        go_idle();
        i_TWIBR     = 16'd4;
        i_SCL_en    = 1'b1;
        i_SCL_start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            exp = ((k / 5) % 2 == 0) ? 1'b1 : 1'b0;
            checks++;
            if (o_SCL !== exp) begin
                errors++;
                $display("FAIL basic k=%0d: o_SCL=%b expected %b", k, o_SCL, exp);
            end
            if (k == 1)  i_SCL_start = 1'b0;
            if (k == 12) i_SCL_start = 1'b1;
            if (k == 13) i_SCL_start = 1'b0;
        end
    endtask

    // TWIBR 4 -> 2 during the first high phase: that phase stays 5, then 3-cycle phases.
    task automatic test_div_change();
        logic exp;
        go_idle();
        i_TWIBR     = 16'd4;
        i_SCL_en    = 1'b1;
        i_SCL_start = 1'b1;
        for (int k = 0; k < 26; k++) begin
            step();
            if (k < 5) exp = 1'b1;
            else       exp = (((k - 5) / 3) % 2 == 0) ? 1'b0 : 1'b1;
            checks++;
            if (o_SCL !== exp) begin
                errors++;
                $display("FAIL div_change k=%0d: o_SCL=%b expected %b", k, o_SCL, exp);
            end
            if (k == 0) i_SCL_start = 1'b0;
            if (k == 2) i_TWIBR = 16'd2;
        end
    endtask

    // Disable mid-low-phase, ignored start while disabled, then a clean restart.
    task automatic test_disable();
        logic exp;
        go_idle();
        i_TWIBR     = 16'd4;
        i_SCL_en    = 1'b1;
        i_SCL_start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            exp = (k < 5) ? 1'b1 : 1'b0;
            checks++;
            if (o_SCL !== exp) begin
                errors++;
                $display("FAIL disable_pre k=%0d: o_SCL=%b expected %b", k, o_SCL, exp);
            end
            if (k == 0) i_SCL_start = 1'b0;
        end
        i_SCL_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (o_SCL !== 1'b1) begin
                errors++;
                $display("FAIL disable_idle cycle %0d: o_SCL=%b expected 1", k, o_SCL);
            end
            if (k == 1) i_SCL_start = 1'b1;
        end
        i_SCL_start = 1'b0;
        step();
        i_SCL_en    = 1'b1;
        i_SCL_start = 1'b1;
        for (int k = 0; k < 13; k++) begin
            step();
            exp = ((k / 5) % 2 == 0) ? 1'b1 : 1'b0;
            checks++;
            if (o_SCL !== exp) begin
                errors++;
                $display("FAIL disable_restart k=%0d: o_SCL=%b expected %b", k, o_SCL, exp);
            end
            if (k == 0) i_SCL_start = 1'b0;
        end
    endtask

    // Enable drops on the edge that would toggle SCL low: the disable wins.
    task automatic test_disable_at_boundary();
        go_idle();
        i_TWIBR     = 16'd4;
        i_SCL_en    = 1'b1;
        i_SCL_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 0) i_SCL_start = 1'b0;
        end
        i_SCL_en = 1'b0;
        for (int k = 5; k < 9; k++) begin
            step();
            checks++;
            if (o_SCL !== 1'b1) begin
                errors++;
                $display("FAIL disable_boundary k=%0d: o_SCL=%b expected 1", k, o_SCL);
            end
        end
    endtask

    // TWIBR=0: SCL toggles on every clock.
    task automatic test_twibr_zero();
        logic exp;
        go_idle();
        i_TWIBR     = 16'd0;
        i_SCL_en    = 1'b1;
        i_SCL_start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            exp = (k % 2 == 0) ? 1'b1 : 1'b0;
            checks++;
            if (o_SCL !== exp) begin
                errors++;
                $display("FAIL twibr_zero k=%0d: o_SCL=%b expected %b", k, o_SCL, exp);
            end
            if (k == 0) i_SCL_start = 1'b0;
        end
    endtask

    // TWIBR=FFFF: first high phase lasts 65536 cycles, then a low phase starts.
    task automatic test_twibr_max();
        int bad;
        int first_bad;
        bad       = 0;
        first_bad = -1;
        go_idle();
        i_TWIBR     = 16'hFFFF;
        i_SCL_en    = 1'b1;
        i_SCL_start = 1'b1;
        for (int k = 0; k < 65536; k++) begin
            step();
            if (k == 0) i_SCL_start = 1'b0;
            if (o_SCL !== 1'b1) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL twibr_max_high: %0d low cycles (first k=%0d) expected 0", bad, first_bad);
        end
        step();
        checks++;
        if (o_SCL !== 1'b0) begin
            errors++;
            $display("FAIL twibr_max_fall k=65536: o_SCL=%b expected 0", o_SCL);
        end
        for (int k = 65537; k < 65541; k++) begin
            step();
            checks++;
            if (o_SCL !== 1'b0) begin
                errors++;
                $display("FAIL twibr_max_low k=%0d: o_SCL=%b expected 0", k, o_SCL);
            end
        end
    endtask

    // Asynchronous reset between edges during a low phase.
    task automatic test_async_reset();
        logic exp;
        go_idle();
        i_TWIBR     = 16'd4;
        i_SCL_en    = 1'b1;
        i_SCL_start = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            if (k == 0) i_SCL_start = 1'b0;
        end
        checks++;
        if (o_SCL !== 1'b0) begin
            errors++;
            $display("FAIL async_pre k=6: o_SCL=%b expected 0", o_SCL);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_SCL !== 1'b1) begin
            errors++;
            $display("FAIL async_immediate: o_SCL=%b expected 1", o_SCL);
        end
        #1;
        i_rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if (o_SCL !== 1'b1) begin
                errors++;
                $display("FAIL async_idle cycle %0d: o_SCL=%b expected 1", k, o_SCL);
            end
        end
        i_SCL_start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            exp = (k < 5) ? 1'b1 : 1'b0;
            checks++;
            if (o_SCL !== exp) begin
                errors++;
                $display("FAIL async_restart k=%0d: o_SCL=%b expected %b", k, o_SCL, exp);
            end
            if (k == 0) i_SCL_start = 1'b0;
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        i_rst_n     = 1'b0;
        i_SCL_start = 1'b0;
        i_SCL_en    = 1'b0;
        i_TWIBR     = 16'd0;
        test_reset();
        test_basic();
        test_div_change();
        test_disable();
        test_disable_at_boundary();
        test_twibr_zero();
        test_twibr_max();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen_scl.md
Name: gen_scl

Overview:
- Programmable SCL clock generator for the I2C master IP.
- Once enabled and kicked by a start pulse, it divides the system clock into a 50% duty-cycle SCL waveform. The half-period is set by the bit-rate register TWIBR.
- SCL idles high (bus released) whenever the generator is not running.
- Sits between the register block (TWIBR, enable) and the I2C master FSM (start), which drives o_SCL onto the bus.

Parameters:
- SIZE_REG, 16, width of the bit-rate register i_TWIBR and of the internal half-period counter.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_SCL_start  input  1  start request; sampled each rising edge; level or pulse accepted.
- i_SCL_en  input  1  generator enable; low forces idle.
- i_TWIBR  input  SIZE_REG  half-period divide value; unsigned.
- o_SCL  output  1  generated SCL; registered output.

Behaviour:
- Reset is asynchronous, active low: state=IDLE, counter=0, latched divider=0, o_SCL=1.
- State machine with two states, IDLE and RUN.
- IDLE:
  - o_SCL held 1 and counter held 0.
  - If i_SCL_en=1 and i_SCL_start=1 at a rising edge: go to RUN, counter=0, latched divider div_q=i_TWIBR, o_SCL stays 1.
  - i_SCL_start with i_SCL_en=0 is ignored.
- RUN, evaluated each rising edge:
  - If i_SCL_en=0: go to IDLE, o_SCL=1, counter=0. This takes effect on that same edge; a partial phase may be truncated.
  - Else if counter==div_q: toggle o_SCL, counter=0, reload div_q from current i_TWIBR.
  - Else: counter=counter+1.
- Timing:
  - Each SCL phase lasts div_q+1 clock cycles; period = 2*(div_q+1); duty 50%.
  - The first transition after start is a falling edge, div_q+1 cycles after the accepting edge. The first high phase equals a normal half period.
- TWIBR changes:
  - Take effect only at a half-period boundary, so no glitch or short phase occurs.
  - The phase in progress completes with the old value.
- TWIBR=0 gives the minimum half-period of 1 cycle (SCL = clk/2).
- i_SCL_start while in RUN is ignored; it does not restart the counter or phase.
- Start and enable asserted on the same edge from IDLE is accepted (see IDLE transition).
- Enable dropping on the same edge as a toggle boundary: the disable wins and o_SCL=1.
- Counter width is SIZE_REG bits. It never wraps, because it is compared against div_q, which is at most 2^SIZE_REG-1.
- Reset mid-RUN immediately forces o_SCL=1 and IDLE, asynchronously.
- No combinational path from inputs to o_SCL.

Test Plan:
- Reset: hold i_rst_n=0 with i_SCL_en=1 and i_SCL_start=1 -> o_SCL=1 throughout; after release with start=0, o_SCL stays 1.
- Basic run: TWIBR=4, en=1, 2-cycle start pulse -> o_SCL falls 5 cycles after the accepting edge, then toggles every 5 cycles (period 10 clk = 100 ns at 100 MHz). The second start cycle has no effect.
- Divider change: while running at TWIBR=4, set TWIBR=2 mid-phase -> current phase finishes at 5 cycles, subsequent phases are 3 cycles each (period 6 clk), with no short pulse.
- Disable: drop en mid-low-phase -> o_SCL=1 on the next edge and stays 1; a later start with en=0 is ignored; re-enable plus start restarts with a full first high phase.
- Edge values: TWIBR=0 -> o_SCL toggles every cycle. TWIBR=16'hFFFF -> half-period of 65536 cycles with no counter wrap.
- Async reset mid-RUN: pulse i_rst_n low between clock edges -> o_SCL=1 immediately; stays idle until a new start.
